// File: rtl/tx_pulse_scheduler.sv
// tx_pulse_scheduler: PA-gated coded transmit pulse scheduler with a programmable PRI.
// Define COMPLEMENTARY_CODE_EN to alternate code_a/code_b on even/odd pulses.
module tx_pulse_scheduler #(
    parameter int CODE_W    = 16,
    parameter int PA_LEAD   = 1229,
    parameter int TX_CYCLES = 19665,
    parameter int PA_LAG    = 1229
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [31:0]       pri_cycles,
    input  logic [15:0]       num_pulses,
    input  logic [CODE_W-1:0] code_a,
    input  logic [CODE_W-1:0] code_b,
    output logic              sinc,
    output logic [CODE_W-1:0] codigo,
    output logic              pa_en,
    output logic              pulse_start,
    output logic [15:0]       pulse_idx,
    output logic              busy,
    output logic              burst_done
);
    typedef enum logic [2:0] {IDLE, LEAD, TX, LAG, WAIT} state_t;

    localparam logic [31:0] PRI_MIN  = 32'(PA_LEAD + TX_CYCLES + PA_LAG + 1);
    localparam logic [31:0] LEAD_END = 32'(PA_LEAD - 1);
    localparam logic [31:0] TX_END   = 32'(TX_CYCLES - 1);
    localparam logic [31:0] LAG_END  = 32'(PA_LAG - 1);

    state_t            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d, pri_cnt_q, pri_cnt_d, pri_q, pri_d;
    logic [15:0]       num_q, num_d, idx_q, idx_d;
    logic [CODE_W-1:0] code_q, code_d, code_sel;
    logic              sinc_q, sinc_d, pa_q, pa_d, start_q, start_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              last, pri_end, new_pulse;

`ifdef COMPLEMENTARY_CODE_EN
    assign code_sel = idx_d[0] ? code_b : code_a;
`else
    logic unused_code_b;
    assign unused_code_b = ^code_b;
    assign code_sel = code_a;
`endif

    assign last    = (num_q != 16'd0) && (idx_q == num_q - 16'd1);
    assign pri_end = pri_cnt_q == pri_q - 32'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 32'd1;
        pri_cnt_d = pri_cnt_q + 32'd1;
        pri_d     = pri_q;
        num_d     = num_q;
        idx_d     = idx_q;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                pri_cnt_d = '0;
                if (enable) begin
                    state_d = LEAD;
                    pri_d   = pri_cycles > PRI_MIN ? pri_cycles : PRI_MIN;
                    num_d   = num_pulses;
                    idx_d   = '0;
                end
            end
            LEAD: if (cnt_q == LEAD_END) begin
                state_d = TX;
                cnt_d   = '0;
            end
            TX: if (cnt_q == TX_END) begin
                state_d = LAG;
                cnt_d   = '0;
            end
            LAG: if (cnt_q == LAG_END) begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (pri_end) begin
                cnt_d     = '0;
                pri_cnt_d = '0;
                state_d   = (last || !enable) ? IDLE : LEAD;
                idx_d     = (last || !enable) ? idx_q : idx_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
        new_pulse = state_d == LEAD && state_q != LEAD;
        code_d    = new_pulse ? code_sel : code_q;
        start_d   = new_pulse;
        sinc_d    = state_d == TX;
        pa_d      = state_d == LEAD || state_d == TX || state_d == LAG;
        busy_d    = state_d != IDLE;
        // Registered strobe must land on the final WAIT cycle, so predict it one cycle early.
        done_d    = state_d == WAIT && pri_cnt_d == pri_q - 32'd1 && last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pri_cnt_q <= '0;
            pri_q     <= '0;
            num_q     <= '0;
            idx_q     <= '0;
            code_q    <= '0;
            sinc_q    <= 1'b0;
            pa_q      <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pri_cnt_q <= pri_cnt_d;
            pri_q     <= pri_d;
            num_q     <= num_d;
            idx_q     <= idx_d;
            code_q    <= code_d;
            sinc_q    <= sinc_d;
            pa_q      <= pa_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sinc        = sinc_q;
    assign codigo      = code_q;
    assign pa_en       = pa_q;
    assign pulse_start = start_q;
    assign pulse_idx   = idx_q;
    assign busy        = busy_q;
    assign burst_done  = done_q;
endmodule

// File: tb/tb_tx_pulse_scheduler.sv
// tb_tx_pulse_scheduler: scoreboard bench; stimulus queues expected pulses/bursts, a negedge monitor checks them.
module tb_tx_pulse_scheduler;
    localparam int LEAD = 4, TXC = 20, LAG = 3, PMIN = LEAD + TXC + LAG + 1;
`ifdef COMPLEMENTARY_CODE_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b0, enable = 1'b0;
    logic [31:0] pri_cycles = '0;
    logic [15:0] num_pulses = '0, code_a = '0, code_b = '0;
    logic        sinc, pa_en, pulse_start, busy, burst_done;
    logic [15:0] codigo, pulse_idx;

    tx_pulse_scheduler #(.CODE_W(16), .PA_LEAD(LEAD), .TX_CYCLES(TXC), .PA_LAG(LAG)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pri_cycles(pri_cycles), .num_pulses(num_pulses),
        .code_a(code_a), .code_b(code_b), .sinc(sinc), .codigo(codigo), .pa_en(pa_en),
        .pulse_start(pulse_start), .pulse_idx(pulse_idx), .busy(busy), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    typedef struct {logic [15:0] idx; logic [15:0] code; bit first;} pulse_t;
    typedef struct {int count; int pri; bit done;} burst_t;

    pulse_t pulse_q[$];
    burst_t burst_q[$];
    int     checks = 0, errors = 0, cyc = 0;

    bit          active = 1'b0;
    burst_t      cur;
    pulse_t      mp;
    int          start0, prev_start, phase, endc, gap, exp_gap;
    logic [15:0] exp_idx, exp_code;
    logic [3:0]  e4, g4;

    // Expected waveform comes straight from the pulse timeline: pa_en over LEAD+TX+LAG, sinc over TX.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            active = 1'b0;
            pulse_q.delete();
            burst_q.delete();
        end else begin
            if (pulse_start) begin
                checks++;
                if (pulse_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse_start cyc=%0d got idx=%0d expected none", cyc, pulse_idx);
                end else begin
                    mp = pulse_q.pop_front();
                    if (mp.first && burst_q.size() != 0) begin
                        cur = burst_q.pop_front();
                        start0 = cyc;
                        active = 1'b1;
                    end
                    gap     = mp.first ? 0 : cyc - prev_start;
                    exp_gap = mp.first ? 0 : cur.pri;
                    if (pulse_idx !== mp.idx || codigo !== mp.code || gap != exp_gap) begin
                        errors++;
                        $display("FAIL pulse_start cyc=%0d got idx=%0d code=%h gap=%0d expected idx=%0d code=%h gap=%0d",
                                 cyc, pulse_idx, codigo, gap, mp.idx, mp.code, exp_gap);
                    end
                    prev_start = cyc;
                    exp_idx    = mp.idx;
                    exp_code   = mp.code;
                end
            end
            g4 = {sinc, pa_en, busy, burst_done};
            checks++;
            if (active) begin
                phase = cyc - prev_start;
                endc  = start0 + cur.count * cur.pri;
                if (cyc >= endc) begin
                    active = 1'b0;
                    if (g4 !== 4'b0000) begin
                        errors++;
                        $display("FAIL burst_end cyc=%0d got sinc/pa/busy/done=%b expected 0000", cyc, g4);
                    end
                end else begin
                    e4 = {phase >= LEAD && phase < LEAD + TXC, phase < LEAD + TXC + LAG, 1'b1,
                          cur.done && cyc == endc - 1};
                    if (g4 !== e4 || pulse_idx !== exp_idx || codigo !== exp_code) begin
                        errors++;
                        $display("FAIL pulse_cycle cyc=%0d phase=%0d got %b idx=%0d code=%h expected %b idx=%0d code=%h",
                                 cyc, phase, g4, pulse_idx, codigo, e4, exp_idx, exp_code);
                    end
                end
            end else if (g4 !== 4'b0000) begin
                errors++;
                $display("FAIL idle_outputs cyc=%0d got sinc/pa/busy/done=%b expected 0000", cyc, g4);
            end
        end
    end

    task automatic wait_start(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (pulse_start) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL start_timeout cyc=%0d got no pulse_start within %0d cycles", cyc, bound);
        end
    endtask

    // chg: 0 = inputs fixed, 1 = code_a becomes new_a mid-TX of pulse 0, 2 = random changes every pulse
    task automatic run_burst(input int n, input int count, input int pri_in,
                             input logic [15:0] a, input logic [15:0] b, input int chg, input logic [15:0] new_a);
        burst_t bt;
        pulse_t pt;
        int     pe;
        bit     ok;
        pe = pri_in > PMIN ? pri_in : PMIN;
        @(negedge clk);
        code_a     = a;
        code_b     = b;
        pri_cycles = 32'(pri_in);
        num_pulses = 16'(n);
        bt = '{count, pe, n != 0};
        burst_q.push_back(bt);
        for (int k = 0; k < count; k++) begin
            pt = '{16'(k), (COMP && k[0]) ? code_b : code_a, k == 0};
            pulse_q.push_back(pt);
            if (k == 0) enable = 1'b1;
            wait_start(pe + 4, ok);
            if (!ok) begin
                enable = 1'b0;
                pulse_q.delete();
                burst_q.delete();
                return;
            end
            repeat (8) @(negedge clk);
            if (k == count - 1) enable = 1'b0;
            if (chg == 1 && k == 0) code_a = new_a;
            if (chg == 2) begin
                code_a     = 16'($urandom);
                code_b     = 16'($urandom);
                pri_cycles = $urandom_range(5, 60);
                num_pulses = 16'($urandom_range(1, 5));
            end
        end
        for (int i = 0; i < pe + 8 && busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got no finish expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt;
        repeat (3) @(negedge clk);
        checks++;
        if ({sinc, pa_en, pulse_start, burst_done, busy, pulse_idx, codigo} !== 37'b0) begin
            errors++;
            $display("FAIL reset_state got %b expected all zero",
                     {sinc, pa_en, pulse_start, burst_done, busy, pulse_idx, codigo});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_burst(3, 3, 40, 16'h1111, 16'h2222, 0, 16'h0);
        run_burst(2, 2, 10, 16'h3333, 16'h4444, 0, 16'h0);
        run_burst(0, 3, 35, 16'h5555, 16'h6666, 0, 16'h0);
        run_burst(4, 4, 30, 16'hA5A5, 16'h5A5A, 0, 16'h0);
        run_burst(3, 3, 40, 16'h1234, 16'h0BAD, 1, 16'hFFFF);

        begin
            burst_t bt;
            pulse_t pt;
            bit     ok;
            @(negedge clk);
            code_a = 16'h7777; code_b = 16'h8888; pri_cycles = 40; num_pulses = 3;
            bt = '{3, 40, 1'b1};
            burst_q.push_back(bt);
            pt = '{16'd0, 16'h7777, 1'b1};
            pulse_q.push_back(pt);
            enable = 1'b1;
            wait_start(8, ok);
            pt = '{16'd1, COMP ? 16'h8888 : 16'h7777, 1'b0};
            pulse_q.push_back(pt);
            wait_start(48, ok);
            repeat (10) @(negedge clk);
            #2 rst = 1'b0;
            #1;
            checks++;
            if ({sinc, pa_en, busy} !== 3'b000) begin
                errors++;
                $display("FAIL async_reset got sinc/pa/busy=%b expected 000", {sinc, pa_en, busy});
            end
            enable = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            repeat (30) @(negedge clk);
            checks++;
            if (busy !== 1'b0 || pulse_idx !== 16'd0) begin
                errors++;
                $display("FAIL post_reset_idle got busy=%b idx=%0d expected busy=0 idx=0", busy, pulse_idx);
            end
        end

        for (int r = 0; r < 6; r++) begin
            n   = $urandom_range(0, 4);
            cnt = n == 0 ? $urandom_range(1, 4) : n;
            run_burst(n, cnt, $urandom_range(5, 60), 16'($urandom), 16'($urandom), 2, 16'h0);
        end

        repeat (5) @(negedge clk);
        checks++;
        if (pulse_q.size() != 0 || burst_q.size() != 0 || active) begin
            errors++;
            $display("FAIL leftover got pulses=%0d bursts=%0d active=%0d expected 0 0 0",
                     pulse_q.size(), burst_q.size(), active);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
